time_keeper_bcd: RTL and testbench

Parametrised BCD time-of-day counter, successor to the fixed HH:MM minute counter in the alarm-clock datapath. Adds an internal prescaler, optional seconds digits, synchronous time load with range checking, an enable, and a runtime 12/24-hour display mode. Feeds the display mux and alarm comparator, and is loaded from the set-time path.

---
 rtl/time_keeper_bcd_if.sv | 34 +++
 rtl/time_keeper_bcd.sv | 155 +++++++++++++++
 tb/tb_time_keeper_bcd.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/time_keeper_bcd_if.sv
// rtl/time_keeper_bcd_if.sv - time-of-day counter control, load and display bundle
interface time_keeper_bcd_if;
  logic       en;
  logic       load;
  logic [3:0] u_sec_in;
  logic [2:0] z_sec_in;
  logic [3:0] u_min_in;
  logic [2:0] z_min_in;
  logic [3:0] u_hour_in;
  logic [1:0] z_hour_in;
  logic       mode_12h;
  logic [3:0] u_sec_out;
  logic [2:0] z_sec_out;
  logic [3:0] u_min_out;
  logic [2:0] z_min_out;
  logic [3:0] u_hour_out;
  logic [1:0] z_hour_out;
  logic       pm;
  logic       tick;
  logic       day_wrap;
  logic       load_err;

  modport master (
    output en, load, u_sec_in, z_sec_in, u_min_in, z_min_in, u_hour_in, z_hour_in, mode_12h,
    input  u_sec_out, z_sec_out, u_min_out, z_min_out, u_hour_out, z_hour_out,
    input  pm, tick, day_wrap, load_err
  );

  modport slave (
    input  en, load, u_sec_in, z_sec_in, u_min_in, z_min_in, u_hour_in, z_hour_in, mode_12h,
    output u_sec_out, z_sec_out, u_min_out, z_min_out, u_hour_out, z_hour_out,
    output pm, tick, day_wrap, load_err
  );
endinterface

// File: rtl/time_keeper_bcd.sv
// rtl/time_keeper_bcd.sv - prescaled BCD time-of-day counter with load and 12/24h display
module time_keeper_bcd #(
  parameter int TICK_DIV    = 1,
  parameter bit HAS_SECONDS = 1'b0
) (
  input logic              clk,
  input logic              rst,
  time_keeper_bcd_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] preCnt;
  logic [3:0] uSec, uMin, uHour;
  logic [2:0] zSec, zMin;
  logic [1:0] zHour;
  logic       tickQ, dayWrapQ, loadErrQ;

  logic [3:0] nUSec, nUMin, nUHour;
  logic [2:0] nZSec, nZMin;
  logic [1:0] nZHour;
  logic       carryMin, carryHour, crossMidnight;
  logic       stepNow, loadOk, secOk, minOk, hourOk;

  assign stepNow = bus.en && (preCnt == PRE_LAST);

  assign secOk  = !HAS_SECONDS || ((bus.u_sec_in <= 4'd9) && (bus.z_sec_in <= 3'd5));
  assign minOk  = (bus.u_min_in <= 4'd9) && (bus.z_min_in <= 3'd5);
  assign hourOk = (bus.u_hour_in <= 4'd9) &&
                  ((bus.z_hour_in < 2'd2) || ((bus.z_hour_in == 2'd2) && (bus.u_hour_in <= 4'd3)));
  assign loadOk = secOk && minOk && hourOk;

  // Without seconds every step is a minute carry.
  assign carryMin      = !HAS_SECONDS || ((uSec == 4'd9) && (zSec == 3'd5));
  assign carryHour     = carryMin && (uMin == 4'd9) && (zMin == 3'd5);
  assign crossMidnight = carryHour && (zHour == 2'd2) && (uHour == 4'd3);

  always_comb begin
    nUSec  = uSec;
    nZSec  = zSec;
    nUMin  = uMin;
    nZMin  = zMin;
    nUHour = uHour;
    nZHour = zHour;
    if (HAS_SECONDS) begin
      if (uSec == 4'd9) begin
        nUSec = 4'd0;
        nZSec = (zSec == 3'd5) ? 3'd0 : zSec + 3'd1;
      end else begin
        nUSec = uSec + 4'd1;
      end
    end
    if (carryMin) begin
      if (uMin == 4'd9) begin
        nUMin = 4'd0;
        nZMin = (zMin == 3'd5) ? 3'd0 : zMin + 3'd1;
      end else begin
        nUMin = uMin + 4'd1;
      end
    end
    if (carryHour) begin
      if (crossMidnight) begin
        nUHour = 4'd0;
        nZHour = 2'd0;
      end else if (uHour == 4'd9) begin
        nUHour = 4'd0;
        nZHour = zHour + 2'd1;
      end else begin
        nUHour = uHour + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      preCnt   <= '0;
      uSec     <= 4'd0;
      zSec     <= 3'd0;
      uMin     <= 4'd0;
      zMin     <= 3'd0;
      uHour    <= 4'd0;
      zHour    <= 2'd0;
      tickQ    <= 1'b0;
      dayWrapQ <= 1'b0;
      loadErrQ <= 1'b0;
    end else begin
      tickQ    <= 1'b0;
      dayWrapQ <= 1'b0;
      loadErrQ <= 1'b0;
      if (bus.load && loadOk) begin
        preCnt <= '0;
        uSec   <= HAS_SECONDS ? bus.u_sec_in : 4'd0;
        zSec   <= HAS_SECONDS ? bus.z_sec_in : 3'd0;
        uMin   <= bus.u_min_in;
        zMin   <= bus.z_min_in;
        uHour  <= bus.u_hour_in;
        zHour  <= bus.z_hour_in;
      end else begin
        if (bus.en) begin
          preCnt <= (preCnt == PRE_LAST) ? '0 : preCnt + PW'(1);
        end
        // A rejected load still owns the time registers, so a coincident step is dropped.
        if (bus.load) begin
          loadErrQ <= 1'b1;
        end else if (stepNow) begin
          uSec     <= nUSec;
          zSec     <= nZSec;
          uMin     <= nUMin;
          zMin     <= nZMin;
          uHour    <= nUHour;
          zHour    <= nZHour;
          tickQ    <= 1'b1;
          dayWrapQ <= crossMidnight;
        end
      end
    end
  end

  logic [3:0] dispUHour;
  logic [1:0] dispZHour;
  logic       isPm;

  assign isPm = (zHour == 2'd2) || ((zHour == 2'd1) && (uHour >= 4'd2));

  always_comb begin
    dispUHour = uHour;
    dispZHour = zHour;
    if (bus.mode_12h) begin
      if ((zHour == 2'd0) && (uHour == 4'd0)) begin
        dispUHour = 4'd2;
        dispZHour = 2'd1;
      end else if ((zHour == 2'd1) && (uHour >= 4'd3)) begin
        dispUHour = uHour - 4'd2;
        dispZHour = 2'd0;
      end else if ((zHour == 2'd2) && (uHour <= 4'd1)) begin
        dispUHour = uHour + 4'd8;
        dispZHour = 2'd0;
      end else if (zHour == 2'd2) begin
        dispUHour = uHour - 4'd2;
        dispZHour = 2'd1;
      end
    end
  end

  assign bus.u_sec_out  = HAS_SECONDS ? uSec : 4'd0;
  assign bus.z_sec_out  = HAS_SECONDS ? zSec : 3'd0;
  assign bus.u_min_out  = uMin;
  assign bus.z_min_out  = zMin;
  assign bus.u_hour_out = dispUHour;
  assign bus.z_hour_out = dispZHour;
  assign bus.pm         = isPm;
  assign bus.tick       = tickQ;
  assign bus.day_wrap   = dayWrapQ;
  assign bus.load_err   = loadErrQ;
endmodule

// File: tb/tb_time_keeper_bcd.sv
// tb/tb_time_keeper_bcd.sv - three configurations of time_keeper_bcd against a seconds-of-day model
module tb_time_keeper_bcd;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_keeper_bcd_if if0 ();
  time_keeper_bcd_if if1 ();
  time_keeper_bcd_if if2 ();

  time_keeper_bcd #(.TICK_DIV(4), .HAS_SECONDS(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  time_keeper_bcd #(.TICK_DIV(1), .HAS_SECONDS(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  time_keeper_bcd #(.TICK_DIV(3), .HAS_SECONDS(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

  int tdA[3] = '{4, 1, 3};
  bit hsA[3] = '{1'b0, 1'b0, 1'b1};

  logic       en, ld, m12;
  logic [3:0] us, um, uh;
  logic [2:0] zs, zm;
  logic [1:0] zh;

  int sod[3], pre[3];
  bit eTick[3], eDw[3], eLe[3];
  int nTests = 0, nFail = 0;

  typedef struct packed {
    logic [3:0] us; logic [2:0] zs; logic [3:0] um; logic [2:0] zm;
    logic [3:0] uh; logic [1:0] zh; logic pm, tick, dw, le;
  } outs_t;

  function automatic outs_t getOut(int k);
    outs_t o;
    case (k)
      0: o = '{if0.u_sec_out, if0.z_sec_out, if0.u_min_out, if0.z_min_out, if0.u_hour_out,
               if0.z_hour_out, if0.pm, if0.tick, if0.day_wrap, if0.load_err};
      1: o = '{if1.u_sec_out, if1.z_sec_out, if1.u_min_out, if1.z_min_out, if1.u_hour_out,
               if1.z_hour_out, if1.pm, if1.tick, if1.day_wrap, if1.load_err};
      default: o = '{if2.u_sec_out, if2.z_sec_out, if2.u_min_out, if2.z_min_out, if2.u_hour_out,
               if2.z_hour_out, if2.pm, if2.tick, if2.day_wrap, if2.load_err};
    endcase
    return o;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push();
    if0.en = en; if0.load = ld; if0.mode_12h = m12;
    if0.u_sec_in = us; if0.z_sec_in = zs; if0.u_min_in = um; if0.z_min_in = zm;
    if0.u_hour_in = uh; if0.z_hour_in = zh;
    if1.en = en; if1.load = ld; if1.mode_12h = m12;
    if1.u_sec_in = us; if1.z_sec_in = zs; if1.u_min_in = um; if1.z_min_in = zm;
    if1.u_hour_in = uh; if1.z_hour_in = zh;
    if2.en = en; if2.load = ld; if2.mode_12h = m12;
    if2.u_sec_in = us; if2.z_sec_in = zs; if2.u_min_in = um; if2.z_min_in = zm;
    if2.u_hour_in = uh; if2.z_hour_in = zh;
  endtask

  task automatic modelReset();
    for (int k = 0; k < 3; k++) begin
      sod[k] = 0; pre[k] = 0; eTick[k] = 0; eDw[k] = 0; eLe[k] = 0;
    end
  endtask

  task automatic modelEdge(int k);
    bit valid, stepNow;
    int hr;
    hr = int'(zh) * 10 + int'(uh);
    valid = (um <= 9) && (zm <= 5) && (uh <= 9) && (hr <= 23) &&
            (!hsA[k] || ((us <= 9) && (zs <= 5)));
    eTick[k] = 0; eDw[k] = 0; eLe[k] = 0;
    if (ld && valid) begin
      sod[k] = hr * 3600 + (int'(zm) * 10 + int'(um)) * 60 +
               (hsA[k] ? int'(zs) * 10 + int'(us) : 0);
      pre[k] = 0;
    end else begin
      stepNow = en && (pre[k] == tdA[k] - 1);
      if (en) pre[k] = stepNow ? 0 : pre[k] + 1;
      if (ld) eLe[k] = 1;
      else if (stepNow) begin
        sod[k] = (sod[k] + (hsA[k] ? 1 : 60)) % 86400;
        eTick[k] = 1;
        eDw[k] = (sod[k] == 0);
      end
    end
  endtask

  task automatic checkModel(int k);
    outs_t o;
    int h, m, s, hd;
    o = getOut(k);
    h = sod[k] / 3600; m = (sod[k] / 60) % 60; s = sod[k] % 60;
    hd = h;
    if (m12) hd = (h % 12 == 0) ? 12 : h % 12;
    chk($sformatf("d%0d_usec", k), 32'(o.us), 32'(s % 10));
    chk($sformatf("d%0d_zsec", k), 32'(o.zs), 32'(s / 10));
    chk($sformatf("d%0d_umin", k), 32'(o.um), 32'(m % 10));
    chk($sformatf("d%0d_zmin", k), 32'(o.zm), 32'(m / 10));
    chk($sformatf("d%0d_uhour", k), 32'(o.uh), 32'(hd % 10));
    chk($sformatf("d%0d_zhour", k), 32'(o.zh), 32'(hd / 10));
    chk($sformatf("d%0d_pm", k), 32'(o.pm), 32'(h >= 12));
    chk($sformatf("d%0d_tick", k), 32'(o.tick), 32'(eTick[k]));
    chk($sformatf("d%0d_daywrap", k), 32'(o.dw), 32'(eDw[k]));
    chk($sformatf("d%0d_loaderr", k), 32'(o.le), 32'(eLe[k]));
  endtask

  task automatic checkAll();
    for (int k = 0; k < 3; k++) checkModel(k);
  endtask

  task automatic cycle();
    push();
    @(posedge clk);
    if (rst) modelReset();
    else for (int k = 0; k < 3; k++) modelEdge(k);
    #1;
    checkAll();
  endtask

  task automatic setTime(int h, int m, int s);
    uh = 4'(h % 10); zh = 2'(h / 10); um = 4'(m % 10); zm = 3'(m / 10);
    us = 4'(s % 10); zs = 3'(s / 10);
  endtask

  task automatic loadCycle(int h, int m, int s);
    setTime(h, m, s);
    ld = 1'b1;
    cycle();
    ld = 1'b0;
  endtask

  initial begin
    outs_t o;
    en = 0; ld = 0; m12 = 0;
    setTime(0, 0, 0);
    modelReset();
    push();
    #1;
    checkAll();
    m12 = 1; push(); #1;
    checkAll();
    o = getOut(2);
    chk("rst_12h_zhour", 32'(o.zh), 32'd1);
    m12 = 0;
    cycle();
    rst = 1'b0;

    // Minute stepping with a 4-cycle prescaler
    en = 1;
    for (int i = 0; i < 4; i++) cycle();
    o = getOut(0);
    chk("p1_first_min", 32'(o.um), 32'd1);
    chk("p1_first_tick", 32'(o.tick), 32'd1);
    for (int i = 0; i < 8; i++) cycle();

    // Midnight crossing on the undivided minute counter
    loadCycle(23, 58, 0);
    o = getOut(1);
    chk("p2_load_tick", 32'(o.tick), 32'd0);
    chk("p2_load_pm", 32'(o.pm), 32'd1);
    cycle();
    o = getOut(1);
    chk("p2_step1_umin", 32'(o.um), 32'd9);
    cycle();
    o = getOut(1);
    chk("p2_wrap_day", 32'(o.dw), 32'd1);
    chk("p2_wrap_tick", 32'(o.tick), 32'd1);
    chk("p2_wrap_pm", 32'(o.pm), 32'd0);

    // Seconds carry into hour tens
    loadCycle(9, 59, 59);
    for (int i = 0; i < 3; i++) cycle();
    o = getOut(2);
    chk("p3_10h_zhour", 32'(o.zh), 32'd1);
    chk("p3_10h_usec", 32'(o.us), 32'd0);
    loadCycle(19, 59, 59);
    for (int i = 0; i < 3; i++) cycle();
    o = getOut(2);
    chk("p3_20h_zhour", 32'(o.zh), 32'd2);
    chk("p3_20h_uhour", 32'(o.uh), 32'd0);

    // Rejected loads with counting paused
    en = 0;
    loadCycle(24, 0, 0);
    o = getOut(0);
    chk("p4_hour24_err", 32'(o.le), 32'd1);
    cycle();
    setTime(12, 0, 0); zm = 3'd6; ld = 1; cycle(); ld = 0;
    setTime(12, 0, 0); um = 4'hA; ld = 1; cycle(); ld = 0;
    o = getOut(1);
    chk("p4_units_err", 32'(o.le), 32'd1);
    cycle();

    // Load on dut0's terminal prescaler cycle, then a frozen stretch
    en = 1;
    loadCycle(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    loadCycle(5, 10, 0);
    o = getOut(0);
    chk("p5_term_load_tick", 32'(o.tick), 32'd0);
    chk("p5_term_load_zmin", 32'(o.zm), 32'd1);
    for (int i = 0; i < 4; i++) cycle();
    en = 0;
    for (int i = 0; i < 10; i++) cycle();

    // 12h display mapping
    m12 = 1;
    loadCycle(0, 30, 0);
    o = getOut(0);
    chk("p6_0030_12h", 32'({o.zh, o.uh}), 32'({2'd1, 4'd2}));
    loadCycle(12, 5, 0);
    loadCycle(13, 45, 0);
    o = getOut(1);
    chk("p6_1345_12h", 32'({o.zh, o.uh}), 32'({2'd0, 4'd1}));
    m12 = 0; push(); #1;
    checkAll();

    // Randomized operation
    for (int i = 0; i < 1500; i++) begin
      en = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) m12 = ~m12;
      case ($urandom_range(0, 3))
        0: begin
          us = 4'($urandom); zs = 3'($urandom); um = 4'($urandom);
          zm = 3'($urandom); uh = 4'($urandom); zh = 2'($urandom);
        end
        1: setTime(23, $urandom_range(58, 59), $urandom_range(55, 59));
        default: setTime($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
      endcase
      cycle();
    end

    // Asynchronous reset between clock edges
    ld = 0; en = 1;
    for (int i = 0; i < 5; i++) cycle();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
